// File: rtl/dbg_regfile_mirror.sv
// dbg_regfile_mirror
// Shadows the core register file and serves a coherent 32-entry byte-lane
// view to the virtual-JTAG readout. A level-based snapshot request from the
// tck domain freezes the view while the core keeps running. Writes that land
// while the view is frozen are counted in lost_writes.
//
// state   | meaning
// --------+-----------------------------------------------------------
// LIVE    | snapshot tracks the forwarded live bank every cycle
// CAPTURE | one cycle: final copy of forwarded view, clear lost count
// HOLD    | snapshot frozen, snap_ack high, count writes (sat. at 255)
// RELEASE | one cycle: ack dropped, snapshot and lost count held

module dbg_regfile_mirror #(
  parameter int XLEN        = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [1:0]      byte_sel,
  input  logic            snap_req,
  output logic            snap_ack,
  output logic [7:0]      r [0:31],
  output logic [7:0]      lost_writes
);

  typedef enum logic [1:0] {
    ST_LIVE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t                 state;
  logic [XLEN-1:0]        live_bank [0:31];
  logic [XLEN-1:0]        snap_bank [0:31];
  logic [XLEN-1:0]        fwd_bank  [0:31];
  logic [SYNC_STAGES-1:0] req_sync;
  logic                   req_s;
  logic                   wr_hit;

  // Entry 0 is hard-wired zero, so writes to it are not real writes.
  assign wr_hit = wr_en && (wr_addr != 5'd0);
  assign req_s  = req_sync[SYNC_STAGES-1];

  // Synchronize the tck-domain request; only the last stage is used.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_sync <= '0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], snap_req};
    end
  end

  // Live bank follows core writeback in every FSM state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        live_bank[i] <= '0;
      end
    end else if (wr_hit) begin
      live_bank[wr_addr] <= wr_data;
    end
  end

  // Forwarded view: a same-cycle write wins over the stale live entry.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      fwd_bank[i] = live_bank[i];
      if (wr_hit && (wr_addr == 5'(i))) begin
        fwd_bank[i] = wr_data;
      end
    end
  end

  // Snapshot FSM with registered ack, lost-write counter and snapshot bank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_LIVE;
      snap_ack    <= 1'b0;
      lost_writes <= 8'd0;
      for (int i = 0; i < 32; i++) begin
        snap_bank[i] <= '0;
      end
    end else begin
      case (state)
        ST_LIVE: begin
          snap_ack <= 1'b0;
          for (int i = 0; i < 32; i++) begin
            snap_bank[i] <= fwd_bank[i];
          end
          if (req_s) begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          for (int i = 0; i < 32; i++) begin
            snap_bank[i] <= fwd_bank[i];
          end
          lost_writes <= 8'd0;
          snap_ack    <= 1'b1;
          state       <= ST_HOLD;
        end
        ST_HOLD: begin
          if (wr_hit && (lost_writes != 8'hFF)) begin
            lost_writes <= lost_writes + 8'd1;
          end
          if (!req_s) begin
            snap_ack <= 1'b0;
            state    <= ST_RELEASE;
          end else begin
            snap_ack <= 1'b1;
          end
        end
        ST_RELEASE: begin
          snap_ack <= 1'b0;
          state    <= ST_LIVE;
        end
        default: begin
          snap_ack <= 1'b0;
          state    <= ST_LIVE;
        end
      endcase
    end
  end

  // Byte-lane select onto the readout array; entry 0 reads as zero.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      r[i] = snap_bank[i][{byte_sel, 3'b000} +: 8];
    end
  end

endmodule

// File: tb/tb_dbg_regfile_mirror.sv
// Randomized bench for dbg_regfile_mirror with a cycle-level reference model
// built from the snapshot rules, plus directed scenarios.

module tb_dbg_regfile_mirror;

  localparam int XLEN = 32;
  localparam int S    = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wr_en;
  logic [4:0]      wr_addr;
  logic [XLEN-1:0] wr_data;
  logic [1:0]      byte_sel;
  logic            snap_req;
  logic            snap_ack;
  logic [7:0]      r [0:31];
  logic [7:0]      lost_writes;

  int checks = 0;
  int errors = 0;

  // reference model
  bit [31:0] m_live [32];
  bit [31:0] m_snap [32];
  bit        req_hist [$];
  string     m_mode;
  bit        m_ack;
  int        m_lost;

  always #5 clk = ~clk;

  dbg_regfile_mirror #(.XLEN(XLEN), .SYNC_STAGES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .byte_sel   (byte_sel),
    .snap_req   (snap_req),
    .snap_ack   (snap_ack),
    .r          (r),
    .lost_writes(lost_writes)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_live[i] = 0;
      m_snap[i] = 0;
    end
    req_hist.delete();
    for (int i = 0; i < S; i++) req_hist.push_back(1'b0);
    m_mode = "LIVE";
    m_ack  = 0;
    m_lost = 0;
  endtask

  // One clock edge of the snapshot rules, applied to the current inputs.
  task automatic model_edge();
    bit [31:0] fwd [32];
    bit        seen_req;
    bit        real_wr;
    if (!rst_n) begin
      model_reset();
      return;
    end
    seen_req = req_hist[S-1];
    req_hist.push_front(snap_req);
    void'(req_hist.pop_back());
    real_wr = wr_en && (wr_addr != 0);
    fwd = m_live;
    if (real_wr) fwd[wr_addr] = wr_data;
    if (m_mode == "LIVE") begin
      m_snap = fwd;
      m_ack  = 0;
      if (seen_req) m_mode = "CAPTURE";
    end else if (m_mode == "CAPTURE") begin
      m_snap = fwd;
      m_lost = 0;
      m_ack  = 1;
      m_mode = "HOLD";
    end else if (m_mode == "HOLD") begin
      if (real_wr && m_lost < 255) m_lost++;
      if (!seen_req) begin
        m_ack  = 0;
        m_mode = "RELEASE";
      end
    end else begin
      m_ack  = 0;
      m_mode = "LIVE";
    end
    m_live = fwd;
  endtask

  function automatic logic [255:0] dut_r();
    logic [255:0] v;
    for (int i = 0; i < 32; i++) v[8*i +: 8] = r[i];
    return v;
  endfunction

  function automatic logic [255:0] model_r();
    logic [255:0] v;
    for (int i = 0; i < 32; i++) v[8*i +: 8] = 8'((m_snap[i] >> (8 * int'(byte_sel))) & 32'hFF);
    return v;
  endfunction

  task automatic check_model();
    chk("model_ack", snap_ack, m_ack);
    chk("model_lost", lost_writes, m_lost);
    chk("model_r", dut_r(), model_r());
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = 5'd0;
    wr_data  = '0;
    byte_sel = 2'd0;
    snap_req = 1'b0;
    model_reset();

    repeat (3) step();
    chk("reset_ack", snap_ack, 1'b0);
    chk("reset_lost", lost_writes, 8'd0);
    chk("reset_r", dut_r(), 256'd0);
    rst_n = 1'b1;
    step();

    // basic write and byte lanes
    wr(5'd5, 32'hA1B2C3D4);
    step();
    chk("x5_lane0", r[5], 8'hD4);
    byte_sel = 2'd3;
    #1;
    chk("x5_lane3", r[5], 8'hA1);
    byte_sel = 2'd0;

    // x0 stays zero
    wr(5'd0, 32'hFFFFFFFF);
    step();
    for (int b = 0; b < 4; b++) begin
      byte_sel = 2'(b);
      #1;
      chk("x0_zero", r[0], 8'h00);
    end
    byte_sel = 2'd0;

    // snapshot with write in the CAPTURE cycle
    wr(5'd7, 32'h11);
    step();
    snap_req = 1'b1;
    repeat (S + 1) step();
    chk("ack_before_capture", snap_ack, 1'b0);
    wr(5'd7, 32'h22);
    chk("ack_rise", snap_ack, 1'b1);
    chk("r7_forwarded", r[7], 8'h22);
    wr(5'd0, 32'h1234);
    chk("x0_not_lost", lost_writes, 8'd0);

    // writes while frozen
    wr(5'd7, 32'h33);
    repeat (3) wr(5'd8, $urandom);
    chk("lost_four", lost_writes, 8'd4);
    chk("r7_frozen", r[7], 8'h22);
    snap_req = 1'b0;
    n = 0;
    while (snap_ack !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    chk("ack_fall_cycles", n, S + 1);
    repeat (3) step();
    chk("r7_after_release", r[7], 8'h33);
    chk("lost_kept", lost_writes, 8'd4);

    // saturation, then clear on next capture
    snap_req = 1'b1;
    repeat (S + 2) step();
    chk("ack_sat_hold", snap_ack, 1'b1);
    for (int k = 0; k < 300; k++) wr(5'($urandom_range(1, 31)), $urandom);
    chk("lost_sat", lost_writes, 8'd255);
    snap_req = 1'b0;
    repeat (S + 3) step();
    chk("lost_sat_kept", lost_writes, 8'd255);
    snap_req = 1'b1;
    repeat (S + 1) step();
    chk("lost_before_capture", lost_writes, 8'd255);
    step();
    chk("lost_cleared", lost_writes, 8'd0);

    // reset while frozen, request still high
    wr(5'd9, 32'hDEADBEEF);
    rst_n = 1'b0;
    step();
    chk("rst_hold_ack", snap_ack, 1'b0);
    chk("rst_hold_lost", lost_writes, 8'd0);
    chk("rst_hold_r", dut_r(), 256'd0);
    rst_n = 1'b1;
    n = 0;
    while (snap_ack !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("ack_after_reset_lat", n, S + 2);
    snap_req = 1'b0;
    repeat (S + 3) step();

    // random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 5'($urandom);
      wr_data = $urandom;
      if ($urandom_range(0, 15) == 0) byte_sel = 2'($urandom);
      if ($urandom_range(0, 19) == 0) snap_req = ~snap_req;
      rst_n = ($urandom_range(0, 399) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
